// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the IFU/LSU memory-port arbiter.
// Build option MEM_ARB_RR_EN selects round-robin arbitration.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  localparam logic [1:0] MEM_ARB_IDLE = 2'd0;
  localparam logic [1:0] MEM_ARB_REQ  = 2'd1;
  localparam logic [1:0] MEM_ARB_WAIT = 2'd2;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick2.sv
// Two-way combinational picker: bit 0 = IFU, bit 1 = LSU.
// ptr = 1 hands a conflict to the IFU, ptr = 0 to the LSU.
module arb_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (valid[1] && (!valid[0] || !ptr)): gnt = 2'b10;
      (valid[0] && (!valid[1] ||  ptr)): gnt = 2'b01;
      default:                           gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin; default is LSU-first priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int MASK_W = DATA_W / 8;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_rsp_q, if_rsp_d;
  logic              ls_rsp_q, ls_rsp_d;

  logic [1:0] gnt;
  logic       idle;
  logic       rr_ptr;

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Point at whoever lost the latest grant.
  always_comb begin
    ptr_d = ptr_q;
    if (ls_req_ready) begin
      ptr_d = 1'b1;
    end else if (if_req_ready) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign rr_ptr = ptr_q;
`else
  assign rr_ptr = 1'b0;
`endif

  arb_pick2 u_pick (
    .valid ({ls_req_valid, if_req_valid}),
    .ptr   (rr_ptr),
    .gnt   (gnt)
  );

  assign idle         = (state_q == MEM_ARB_IDLE);
  assign if_req_ready = idle && gnt[0];
  assign ls_req_ready = idle && gnt[1];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_rsp_d   = 1'b0;
    ls_rsp_d   = 1'b0;
    unique case (state_q)
      MEM_ARB_IDLE: begin
        if (ls_req_ready) begin
          state_d = MEM_ARB_REQ;
          owner_d = OWNER_LS;
          we_d    = ls_we;
          addr_d  = ls_addr;
          wdata_d = ls_wdata;
          wmask_d = ls_wmask;
        end else if (if_req_ready) begin
          state_d = MEM_ARB_REQ;
          owner_d = OWNER_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          wmask_d = '0;
        end
      end
      MEM_ARB_REQ: begin
        if (mem_req_ready) begin
          state_d = MEM_ARB_WAIT;
        end
      end
      MEM_ARB_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = MEM_ARB_IDLE;
          if (owner_q == OWNER_LS) begin
            ls_rdata_d = we_q ? '0 : mem_rdata;
            ls_rsp_d   = 1'b1;
          end else begin
            if_rdata_d = we_q ? '0 : mem_rdata;
            if_rsp_d   = 1'b1;
          end
        end
      end
      default: state_d = MEM_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MEM_ARB_IDLE;
      owner_q    <= OWNER_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_rsp_q   <= 1'b0;
      ls_rsp_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_rsp_q   <= if_rsp_d;
      ls_rsp_q   <= ls_rsp_d;
    end
  end

  assign mem_req_valid = (state_q == MEM_ARB_REQ);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign if_rsp_valid  = if_rsp_q;
  assign if_rdata      = if_rdata_q;
  assign ls_rsp_valid  = ls_rsp_q;
  assign ls_rdata      = ls_rdata_q;
  assign busy          = !idle;
  assign owner         = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cases then random traffic.
// Build with MEM_ARB_RR_EN to check the round-robin variant.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid, busy, owner;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_addr(if_addr), .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        own;
  } req_t;

  typedef struct {
    logic        own;
    logic [63:0] data;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  int vecs = 0;
  int errs = 0;

  bit          req_auto = 0, mem_auto = 0, stray_en = 0;
  int          density = 0;
  bit          outstanding = 0, out_own, out_we;
  int          rsp_cnt = 0;
  bit          last_ls = 0;
  bit          if_acc = 0, ls_acc = 0;
  logic [63:0] mdl_if_rdata = '0, mdl_ls_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake recorder: pushes expectations for what will happen at the
  // next rising edge, and checks arbitration decisions.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      exp_req_q.delete();
      exp_rsp_q.delete();
      outstanding  = 0;
      last_ls      = 0;
      mdl_if_rdata = '0;
      mdl_ls_rdata = '0;
    end else begin
      if (if_req_ready || ls_req_ready) begin
        chk("dual_ready", 64'(if_req_ready && ls_req_ready), 0);
        chk("ready_busy", 64'(busy), 0);
      end
      if (!busy && (if_req_valid || ls_req_valid))
        chk("grant_idle", 64'(if_req_ready || ls_req_ready), 1);
      if (if_req_valid && ls_req_valid && (if_req_ready || ls_req_ready)) begin
`ifdef MEM_ARB_RR_EN
        chk("arb_winner", 64'(ls_req_ready), 64'(!last_ls));
`else
        chk("arb_winner", 64'(ls_req_ready), 1);
`endif
      end
      if (ls_req_valid && ls_req_ready) begin
        exp_req_q.push_back('{ls_we, ls_addr, ls_wdata, ls_wmask, 1'b1});
        ls_acc  = 1;
        last_ls = 1;
      end else if (if_req_valid && if_req_ready) begin
        exp_req_q.push_back('{1'b0, if_addr, 64'h0, 8'h0, 1'b0});
        if_acc  = 1;
        last_ls = 0;
      end
      if (mem_rsp_valid && outstanding) begin
        exp_rsp_q.push_back('{out_own, out_we ? 64'h0 : mem_rdata});
        outstanding = 0;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req_q.size() == 0) begin
          chk("mem_req_unexpected", 1, 0);
        end else begin
          req_t r;
          r = exp_req_q.pop_front();
          chk("mem_we", 64'(mem_we), 64'(r.we));
          chk("mem_addr", mem_addr, r.addr);
          chk("mem_wdata", mem_wdata, r.wdata);
          chk("mem_wmask", 64'(mem_wmask), 64'(r.wmask));
          chk("owner", 64'(owner), 64'(r.own));
          outstanding = 1;
          out_own     = r.own;
          out_we      = r.we;
          rsp_cnt     = $urandom_range(0, 3);
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (if_rsp_valid && ls_rsp_valid) chk("dual_rsp", 1, 0);
      if (if_rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          chk("if_rsp_unexpected", 1, 0);
        end else begin
          rsp_t r;
          r = exp_rsp_q.pop_front();
          chk("if_rsp_owner", 64'(r.own), 0);
          chk("if_rdata", if_rdata, r.data);
          mdl_if_rdata = r.data;
        end
      end
      if (ls_rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          chk("ls_rsp_unexpected", 1, 0);
        end else begin
          rsp_t r;
          r = exp_rsp_q.pop_front();
          chk("ls_rsp_owner", 64'(r.own), 1);
          chk("ls_rdata", ls_rdata, r.data);
          mdl_ls_rdata = r.data;
        end
      end
    end
  end

  // Random requesters.
  always @(negedge clk) begin
    if (req_auto) begin
      if (if_acc) begin
        if_acc = 0;
        if_req_valid = 1'b0;
        if ($urandom_range(0, 99) < density) begin
          if_req_valid = 1'b1;
          if_addr = {$urandom, $urandom};
        end
      end else if (!if_req_valid && $urandom_range(0, 99) < density) begin
        if_req_valid = 1'b1;
        if_addr = {$urandom, $urandom};
      end else if (if_req_valid && density < 100 && $urandom_range(0, 15) == 0) begin
        if_req_valid = 1'b0;
      end
      if (ls_acc) begin
        ls_acc = 0;
        ls_req_valid = 1'b0;
      end
      if (!ls_req_valid && $urandom_range(0, 99) < density) begin
        ls_req_valid = 1'b1;
        ls_we    = 1'($urandom);
        ls_addr  = {$urandom, $urandom};
        ls_wdata = {$urandom, $urandom};
        ls_wmask = 8'($urandom);
      end
    end
  end

  // Random memory.
  always @(negedge clk) begin
    if (mem_auto) begin
      mem_req_ready = ($urandom_range(0, 2) != 0);
      mem_rsp_valid = 1'b0;
      mem_rdata     = {$urandom, $urandom};
      if (outstanding) begin
        if (rsp_cnt == 0) mem_rsp_valid = 1'b1;
        else rsp_cnt--;
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        mem_rsp_valid = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int n;
    rst_n = 0;
    if_req_valid = 0; if_addr = '0;
    ls_req_valid = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    repeat (3) cyc();
    settle();
    chk("rst_if_ready", 64'(if_req_ready), 0);
    chk("rst_ls_ready", 64'(ls_req_ready), 0);
    chk("rst_if_rsp", 64'(if_rsp_valid), 0);
    chk("rst_ls_rsp", 64'(ls_rsp_valid), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_mem_valid", 64'(mem_req_valid), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", 64'(mem_wmask), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_owner", 64'(owner), 0);
    cyc();
    rst_n = 1;

    // IFU-only fetch, one wait cycle.
    cyc();
    if_req_valid = 1; if_addr = 64'h8000_0000;
    settle();
    chk("t1_if_ready", 64'(if_req_ready), 1);
    chk("t1_mem_valid_pre", 64'(mem_req_valid), 0);
    cyc();
    if_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("t1_mem_valid", 64'(mem_req_valid), 1);
    chk("t1_mem_we", 64'(mem_we), 0);
    cyc();
    mem_req_ready = 0;
    cyc();
    mem_rsp_valid = 1; mem_rdata = 64'h0000_0013_0010_0073;
    cyc();
    mem_rsp_valid = 0;
    settle();
    chk("t1_if_rsp", 64'(if_rsp_valid), 1);
    chk("t1_if_rdata", if_rdata, 64'h0000_0013_0010_0073);
    chk("t1_ls_rsp", 64'(ls_rsp_valid), 0);
    cyc();
    settle();
    chk("t1_if_rsp_once", 64'(if_rsp_valid), 0);
    chk("t1_ls_rsp_after", 64'(ls_rsp_valid), 0);

    // Simultaneous IFU fetch and LSU store.
    cyc();
    if_req_valid = 1; if_addr = 64'h8000_0004;
    ls_req_valid = 1; ls_we = 1; ls_addr = 64'h8000_1000;
    ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'hFF;
    settle();
    chk("t2_ls_ready", 64'(ls_req_ready), 1);
    chk("t2_if_ready", 64'(if_req_ready), 0);
    cyc();
    ls_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("t2_mem_we", 64'(mem_we), 1);
    chk("t2_mem_wmask", 64'(mem_wmask), 64'hFF);
    chk("t2_mem_addr", mem_addr, 64'h8000_1000);
    cyc();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    cyc();
    mem_rsp_valid = 0;
    settle();
    chk("t2_ls_rsp", 64'(ls_rsp_valid), 1);
    chk("t2_ls_rdata", ls_rdata, 0);
    chk("t2_if_grant_b2b", 64'(if_req_ready), 1);
    cyc();
    if_req_valid = 0; mem_req_ready = 1;
    settle();
    chk("t2_if_addr", mem_addr, 64'h8000_0004);
    cyc();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 64'h0000_0000_0040_0093;
    cyc();
    mem_rsp_valid = 0;
    settle();
    chk("t2_if_rsp", 64'(if_rsp_valid), 1);

    // Memory stalls five cycles; IFU request withdrawn meanwhile.
    cyc();
    a = {$urandom, $urandom};
    ls_req_valid = 1; ls_we = 0; ls_addr = a; ls_wdata = 64'h55; ls_wmask = 8'h0F;
    settle();
    chk("t3_ls_ready", 64'(ls_req_ready), 1);
    cyc();
    ls_req_valid = 0; if_req_valid = 1; if_addr = 64'h8000_0100;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t3_stall_valid", 64'(mem_req_valid), 1);
      chk("t3_stall_addr", mem_addr, a);
      chk("t3_stall_mask", 64'(mem_wmask), 64'h0F);
      chk("t3_stall_if_ready", 64'(if_req_ready), 0);
      cyc();
    end
    if_req_valid = 0; mem_req_ready = 1; mem_rsp_valid = 1;
    mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    cyc();
    mem_req_ready = 0; mem_rsp_valid = 0;
    settle();
    chk("t3_same_cycle_rsp_ignored", 64'(busy), 1);
    cyc();
    mem_rsp_valid = 1; mem_rdata = 64'hCAFE_F00D_0BAD_1DEA;
    cyc();
    mem_rsp_valid = 0;
    settle();
    chk("t3_ls_rsp", 64'(ls_rsp_valid), 1);
    cyc();
    cyc();
    settle();
    chk("t3_withdraw_idle", 64'(busy), 0);

    // Stray responses while idle.
    for (int i = 0; i < 3; i++) begin
      cyc();
      mem_rsp_valid = (i < 2);
      mem_rdata = {$urandom, $urandom};
      settle();
      chk("t4_if_rsp", 64'(if_rsp_valid), 0);
      chk("t4_ls_rsp", 64'(ls_rsp_valid), 0);
      chk("t4_if_rdata", if_rdata, mdl_if_rdata);
      chk("t4_ls_rdata", ls_rdata, mdl_ls_rdata);
    end

    // Reset while waiting for the response.
    cyc();
    ls_req_valid = 1; ls_we = 0; ls_addr = 64'h8000_2000;
    cyc();
    ls_req_valid = 0; mem_req_ready = 1;
    cyc();
    mem_req_ready = 0;
    settle();
    chk("t5_in_wait", 64'(busy), 1);
    cyc();
    rst_n = 0;
    settle();
    chk("t5_busy", 64'(busy), 0);
    chk("t5_owner", 64'(owner), 0);
    chk("t5_mem_valid", 64'(mem_req_valid), 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_ls_rdata", ls_rdata, 0);
    chk("t5_if_rdata", if_rdata, 0);
    cyc();
    rst_n = 1; mem_rsp_valid = 1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    cyc();
    mem_rsp_valid = 0;
    settle();
    chk("t5_no_rsp", 64'(ls_rsp_valid), 0);
    chk("t5_idle", 64'(busy), 0);
    chk("t5_rdata_zero", ls_rdata, 0);
    cyc();
    settle();
    chk("t5_no_rsp_late", 64'(ls_rsp_valid | if_rsp_valid), 0);

    // Both requesters continuously valid, then random traffic.
    if_acc = 0; ls_acc = 0;
    density = 100; req_auto = 1; mem_auto = 1; stray_en = 0;
    repeat (60) cyc();
    density = 40; stray_en = 1;
    repeat (3000) cyc();
    density = 0; stray_en = 0;
    n = 0;
    while (n < 400 && (if_req_valid || ls_req_valid || busy ||
                       exp_req_q.size() != 0 || exp_rsp_q.size() != 0)) begin
      cyc();
      n++;
    end
    if (n >= 400) chk("drain_timeout", 1, 0);
    req_auto = 0; mem_auto = 0;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
